// File: rtl/sudoku_fsm.sv
// Sudoku game controller: title, difficulty select, board load, cursor navigation,
// digit entry and victory detection. Owns the 9x9 board array cell_value[x][y].
module sudoku_fsm #(
  parameter int LOAD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic       a_button,
  input  logic       b_button,
  input  logic       up_button,
  input  logic       down_button,
  input  logic       left_button,
  input  logic       right_button,
  output logic [2:0] current_state,
  output logic       title_display,
  output logic       difficulty_display,
  output logic       running_display,
  output logic       easy_selected,
  output logic       hard_selected,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y
);

  typedef enum logic [2:0] {
    Q0_INICIAR_JOGO      = 3'b000,
    Q1_SELEC_DIFICULDADE = 3'b001,
    CARREGANDO           = 3'b010,
    CORRENDO_MAPA        = 3'b011,
    PERCORRER_NUMEROS    = 3'b100,
    VITORIA              = 3'b101
  } state_t;

  localparam int CNT_W = $clog2(LOAD_CYCLES + 1);

  state_t           state, next_state;
  logic [3:0]       cell_value [0:8][0:8];
  logic [3:0]       candidate;
  logic             easy_choice;
  logic [CNT_W-1:0] load_cnt;
  logic             load_done;
  logic [6:0]       btn_level, btn_prev, btn_press;
  logic             act_a, act_b, act_start, act_up, act_down, act_left, act_right;
  logic             solved;
  logic [15:0]      row_m, col_m, box_m;

  assign btn_level = {a_button, b_button, start_button, up_button,
                      down_button, left_button, right_button};
  assign btn_press = btn_level & ~btn_prev;
  assign load_done = (load_cnt == CNT_W'(LOAD_CYCLES - 1));

  // Only the highest-priority new press is allowed to act in a given cycle.
  always_comb begin
    {act_a, act_b, act_start, act_up, act_down, act_left, act_right} = 7'b0;
    if (btn_press[6])      act_a     = 1'b1;
    else if (btn_press[5]) act_b     = 1'b1;
    else if (btn_press[4]) act_start = 1'b1;
    else if (btn_press[3]) act_up    = 1'b1;
    else if (btn_press[2]) act_down  = 1'b1;
    else if (btn_press[1]) act_left  = 1'b1;
    else if (btn_press[0]) act_right = 1'b1;
  end

  // A group is valid iff its digit set covers exactly 1..9; zeros or repeats leave a gap.
  always_comb begin
    solved = 1'b1;
    row_m  = '0;
    col_m  = '0;
    box_m  = '0;
    for (int g = 0; g < 9; g++) begin
      row_m = '0;
      col_m = '0;
      box_m = '0;
      for (int k = 0; k < 9; k++) begin
        row_m = row_m | (16'd1 << cell_value[4'(k)][4'(g)]);
        col_m = col_m | (16'd1 << cell_value[4'(g)][4'(k)]);
        box_m = box_m | (16'd1 << cell_value[4'((g % 3) * 3 + k % 3)][4'((g / 3) * 3 + k / 3)]);
      end
      if (((row_m & 16'h03FE) != 16'h03FE) ||
          ((col_m & 16'h03FE) != 16'h03FE) ||
          ((box_m & 16'h03FE) != 16'h03FE))
        solved = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= Q0_INICIAR_JOGO;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      Q0_INICIAR_JOGO:      if (act_start) next_state = Q1_SELEC_DIFICULDADE;
      Q1_SELEC_DIFICULDADE: begin
        if (act_a)      next_state = CARREGANDO;
        else if (act_b) next_state = Q0_INICIAR_JOGO;
      end
      CARREGANDO:           if (load_done) next_state = CORRENDO_MAPA;
      CORRENDO_MAPA: begin
        if (solved)     next_state = VITORIA;
        else if (act_a) next_state = PERCORRER_NUMEROS;
      end
      PERCORRER_NUMEROS:    if (act_a || act_b) next_state = CORRENDO_MAPA;
      VITORIA:              if (act_start) next_state = Q0_INICIAR_JOGO;
      default:              next_state = Q0_INICIAR_JOGO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_prev    <= '0;
      easy_choice <= 1'b1;
      cursor_x    <= '0;
      cursor_y    <= '0;
      candidate   <= '0;
      load_cnt    <= '0;
      for (int x = 0; x < 9; x++)
        for (int y = 0; y < 9; y++)
          cell_value[4'(x)][4'(y)] <= '0;
    end else begin
      btn_prev <= btn_level;
      load_cnt <= '0;
      case (state)
        Q1_SELEC_DIFICULDADE: begin
          if (act_up)        easy_choice <= 1'b1;
          else if (act_down) easy_choice <= 1'b0;
        end
        CARREGANDO: begin
          cursor_x <= '0;
          cursor_y <= '0;
          load_cnt <= load_done ? '0 : load_cnt + 1'b1;
          for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
              cell_value[4'(x)][4'(y)] <= '0;
        end
        CORRENDO_MAPA: begin
          if (!solved) begin
            if (act_up)         cursor_y  <= (cursor_y == 4'd0) ? 4'd8 : cursor_y - 4'd1;
            else if (act_down)  cursor_y  <= (cursor_y == 4'd8) ? 4'd0 : cursor_y + 4'd1;
            else if (act_left)  cursor_x  <= (cursor_x == 4'd0) ? 4'd8 : cursor_x - 4'd1;
            else if (act_right) cursor_x  <= (cursor_x == 4'd8) ? 4'd0 : cursor_x + 4'd1;
            else if (act_a)     candidate <= cell_value[cursor_x][cursor_y];
          end
        end
        PERCORRER_NUMEROS: begin
          if (act_up)        candidate <= (candidate >= 4'd9) ? 4'd1 : candidate + 4'd1;
          else if (act_down) candidate <= (candidate <= 4'd1) ? 4'd9 : candidate - 4'd1;
          else if (act_a)    cell_value[cursor_x][cursor_y] <= candidate;
        end
        default: ;
      endcase
    end
  end

  assign current_state      = state;
  assign title_display      = (state == Q0_INICIAR_JOGO);
  assign difficulty_display = (state == Q1_SELEC_DIFICULDADE);
  assign running_display    = (state == CORRENDO_MAPA) || (state == PERCORRER_NUMEROS);
  assign easy_selected      = easy_choice;
  assign hard_selected      = ~easy_choice;

endmodule

// File: tb/tb_sudoku_fsm.sv
// Directed bench for sudoku_fsm: a game-rule model is checked against the DUT every cycle,
// plus literal expectations at the key points of each scenario.
module tb_sudoku_fsm;
  localparam int LOAD_CYCLES = 4;

  localparam logic [6:0] K_A     = 7'b1000000;
  localparam logic [6:0] K_B     = 7'b0100000;
  localparam logic [6:0] K_START = 7'b0010000;
  localparam logic [6:0] K_UP    = 7'b0001000;
  localparam logic [6:0] K_DOWN  = 7'b0000100;
  localparam logic [6:0] K_LEFT  = 7'b0000010;
  localparam logic [6:0] K_RIGHT = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] keys = '0;
  logic       start_button, a_button, b_button, up_button, down_button, left_button, right_button;
  logic [2:0] current_state;
  logic       title_display, difficulty_display, running_display, easy_selected, hard_selected;
  logic [3:0] cursor_x, cursor_y;

  assign {a_button, b_button, start_button, up_button, down_button, left_button, right_button} = keys;

  sudoku_fsm #(.LOAD_CYCLES(LOAD_CYCLES)) dut (
    .clk(clk), .reset(reset),
    .start_button(start_button), .a_button(a_button), .b_button(b_button),
    .up_button(up_button), .down_button(down_button),
    .left_button(left_button), .right_button(right_button),
    .current_state(current_state), .title_display(title_display),
    .difficulty_display(difficulty_display), .running_display(running_display),
    .easy_selected(easy_selected), .hard_selected(hard_selected),
    .cursor_x(cursor_x), .cursor_y(cursor_y)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;
  bit checking = 1'b0;

  // Game model: state codes 0 title, 1 difficulty, 2 loading, 3 map, 4 digit pick, 5 victory.
  int         m_state = 0, m_cx = 0, m_cy = 0, m_cand = 0, m_cnt = 0;
  bit         m_easy = 1'b1;
  logic [6:0] m_prev = '0;
  int         m_board [9][9];

  function automatic bit model_solved();
    for (int x = 0; x < 9; x++)
      for (int y = 0; y < 9; y++)
        if (m_board[x][y] == 0) return 1'b0;
    for (int i = 0; i < 9; i++)
      for (int p = 0; p < 9; p++)
        for (int q = p + 1; q < 9; q++) begin
          if (m_board[p][i] == m_board[q][i]) return 1'b0;
          if (m_board[i][p] == m_board[i][q]) return 1'b0;
          if (m_board[(i % 3) * 3 + p % 3][(i / 3) * 3 + p / 3] ==
              m_board[(i % 3) * 3 + q % 3][(i / 3) * 3 + q / 3]) return 1'b0;
        end
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [6:0] press;
    int act;
    if (!reset) begin
      m_state = 0; m_easy = 1'b1; m_cx = 0; m_cy = 0; m_cand = 0; m_cnt = 0; m_prev = '0;
      foreach (m_board[x, y]) m_board[x][y] = 0;
    end else begin
      press  = keys & ~m_prev;
      m_prev = keys;
      act = -1;
      for (int i = 6; i >= 0; i--)
        if (press[i] && act < 0) act = i;
      case (m_state)
        0: if (act == 4) m_state = 1;
        1: begin
          if (act == 3)      m_easy = 1'b1;
          else if (act == 2) m_easy = 1'b0;
          else if (act == 6) begin m_state = 2; m_cnt = 0; end
          else if (act == 5) m_state = 0;
        end
        2: begin
          foreach (m_board[x, y]) m_board[x][y] = 0;
          m_cx = 0; m_cy = 0;
          m_cnt++;
          if (m_cnt == LOAD_CYCLES) m_state = 3;
        end
        3: begin
          if (model_solved()) m_state = 5;
          else if (act == 3) m_cy = (m_cy + 8) % 9;
          else if (act == 2) m_cy = (m_cy + 1) % 9;
          else if (act == 1) m_cx = (m_cx + 8) % 9;
          else if (act == 0) m_cx = (m_cx + 1) % 9;
          else if (act == 6) begin m_cand = m_board[m_cx][m_cy]; m_state = 4; end
        end
        4: begin
          if (act == 3)      m_cand = m_cand % 9 + 1;
          else if (act == 2) m_cand = (m_cand <= 1) ? 9 : m_cand - 1;
          else if (act == 6) begin m_board[m_cx][m_cy] = m_cand; m_state = 3; end
          else if (act == 5) m_state = 3;
        end
        5: if (act == 4) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  always @(posedge clk) model_step();

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vectors++;
    if (actual != expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int dut_cell(input int x, input int y);
    return int'(dut.cell_value[x][y]);
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      int bad;
      checkOutput("current_state", current_state, m_state);
      checkOutput("title_display", title_display, (m_state == 0) ? 1 : 0);
      checkOutput("difficulty_display", difficulty_display, (m_state == 1) ? 1 : 0);
      checkOutput("running_display", running_display, (m_state == 3 || m_state == 4) ? 1 : 0);
      checkOutput("easy_selected", easy_selected, m_easy ? 1 : 0);
      checkOutput("hard_selected", hard_selected, m_easy ? 0 : 1);
      checkOutput("cursor_x", cursor_x, m_cx);
      checkOutput("cursor_y", cursor_y, m_cy);
      bad = 0;
      for (int x = 0; x < 9; x++)
        for (int y = 0; y < 9; y++)
          if (dut_cell(x, y) != m_board[x][y]) bad++;
      checkOutput("board_cells_differing", bad, 0);
    end
  end

  task automatic applyStimulus(input logic [6:0] k);
    @(negedge clk);
    keys = k;
    @(negedge clk);
    keys = '0;
  endtask

  task automatic hold_key(input logic [6:0] k, input int n);
    @(negedge clk);
    keys = k;
    repeat (n) @(negedge clk);
    keys = '0;
  endtask

  task automatic enter_digit(input int d);
    applyStimulus(K_A);
    repeat (d) applyStimulus(K_UP);
    applyStimulus(K_A);
  endtask

  function automatic int sol(input int x, input int y);
    return ((y * 3 + y / 3 + x) % 9) + 1;
  endfunction

  // Raster entry; each row ends with the cursor wrapped back to column 0, then moves down.
  task automatic fill_board(input bit skip_last, input bit dup);
    for (int y = 0; y < 9; y++) begin
      for (int x = 0; x < 9; x++) begin
        if (!(skip_last && x == 8 && y == 8))
          enter_digit((dup && x == 0 && y == 0) ? sol(1, 0) : sol(x, y));
        applyStimulus(K_RIGHT);
      end
      applyStimulus(K_DOWN);
    end
  endtask

  initial begin
    foreach (m_board[x, y]) m_board[x][y] = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checking = 1'b1;
    checkOutput("lit_reset_state", current_state, 0);
    checkOutput("lit_reset_title", title_display, 1);
    checkOutput("lit_reset_cursor", {cursor_x, cursor_y}, 0);
    checkOutput("lit_reset_easy", easy_selected, 1);

    applyStimulus(K_DOWN);
    applyStimulus(K_A);
    checkOutput("lit_q0_ignores_keys", current_state, 0);
    applyStimulus(K_START);
    checkOutput("lit_q1_state", current_state, 1);
    applyStimulus(K_DOWN);
    applyStimulus(K_DOWN);
    checkOutput("lit_hard_selected", hard_selected, 1);
    applyStimulus(K_UP);
    checkOutput("lit_easy_again", easy_selected, 1);
    applyStimulus(K_DOWN);

    applyStimulus(K_A);
    for (int i = 0; i < LOAD_CYCLES; i++) begin
      checkOutput("lit_loading_state", current_state, 2);
      @(negedge clk);
    end
    checkOutput("lit_map_state", current_state, 3);
    checkOutput("lit_running", running_display, 1);
    checkOutput("lit_hard_latched", hard_selected, 1);

    applyStimulus(K_UP);
    checkOutput("lit_nav_up", {cursor_x, cursor_y}, 8'h08);
    applyStimulus(K_LEFT);
    checkOutput("lit_nav_left", {cursor_x, cursor_y}, 8'h88);
    applyStimulus(K_DOWN);
    checkOutput("lit_nav_down", {cursor_x, cursor_y}, 8'h80);
    applyStimulus(K_RIGHT);
    checkOutput("lit_nav_right", {cursor_x, cursor_y}, 8'h00);
    applyStimulus(K_B);
    applyStimulus(K_START);
    checkOutput("lit_map_ignores_b_start", current_state, 3);
    hold_key(K_RIGHT, 4);
    checkOutput("lit_held_no_repeat", cursor_x, 1);
    applyStimulus(K_LEFT);

    enter_digit(4);
    checkOutput("lit_cell00", dut_cell(0, 0), 4);
    checkOutput("lit_model_cell00", m_board[0][0], 4);
    applyStimulus(K_LEFT);
    enter_digit(11);
    checkOutput("lit_cell80_wrap", dut_cell(8, 0), 2);

    applyStimulus(K_UP);
    applyStimulus(K_UP);
    applyStimulus(K_A);
    repeat (5) applyStimulus(K_UP);
    applyStimulus(K_B);
    checkOutput("lit_cancel_state", current_state, 3);
    checkOutput("lit_cancel_cell87", dut_cell(8, 7), 0);
    applyStimulus(K_A | K_UP);
    checkOutput("lit_a_over_up_state", current_state, 4);
    checkOutput("lit_a_over_up_cursor", {cursor_x, cursor_y}, 8'h87);
    applyStimulus(K_LEFT);
    checkOutput("lit_cursor_frozen", cursor_x, 8);
    applyStimulus(K_DOWN);
    applyStimulus(K_A);
    checkOutput("lit_down_wrap_cell87", dut_cell(8, 7), 9);
    applyStimulus(K_B | K_UP);
    checkOutput("lit_b_over_up", cursor_y, 7);

    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    checkOutput("lit_rereset_state", current_state, 0);
    checkOutput("lit_rereset_cell00", dut_cell(0, 0), 0);

    applyStimulus(K_START);
    applyStimulus(K_A);
    repeat (LOAD_CYCLES) @(negedge clk);
    fill_board(1'b1, 1'b0);
    applyStimulus(K_UP);
    applyStimulus(K_LEFT);
    checkOutput("lit_not_yet_solved", current_state, 3);
    enter_digit(sol(8, 8));
    @(negedge clk);
    checkOutput("lit_victory", current_state, 5);
    applyStimulus(K_UP);
    checkOutput("lit_victory_ignores_up", current_state, 5);
    applyStimulus(K_START);
    checkOutput("lit_victory_to_title", current_state, 0);
    checkOutput("lit_board_kept", dut_cell(8, 8), 8);

    applyStimulus(K_START);
    applyStimulus(K_A);
    repeat (LOAD_CYCLES) @(negedge clk);
    checkOutput("lit_load_cleared", dut_cell(8, 8), 0);
    fill_board(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("lit_dup_row_not_solved", current_state, 3);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
